// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with fill count,
// almost-full/almost-empty thresholds and a registered read port.
// Every RAM entry is usable. The pointers carry one extra wrap bit, which
// tells full apart from empty.
// Optional feature macro: LCD_FIFO_ERR_EN adds the sticky overflow/underflow
// flags and their clear input. When the macro is undefined, those ports and
// their logic do not exist.
module fifo_sync_param #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 8,
    parameter int ALMOST_FULL_LEVEL  = (1 << ADDR_WIDTH) - 4,
    parameter int ALMOST_EMPTY_LEVEL = 4
) (
    input  logic                  i_clock,
    input  logic                  i_nReset,
    input  logic [DATA_WIDTH-1:0] i_writeData,
    input  logic                  i_writeEnable,
    output logic                  o_full,
    output logic                  o_almostFull,
    input  logic                  i_readEnable,
    output logic [DATA_WIDTH-1:0] o_readData,
    output logic                  o_readValid,
    output logic                  o_empty,
    output logic                  o_almostEmpty,
    output logic [ADDR_WIDTH:0]   o_fillCount
`ifdef LCD_FIFO_ERR_EN
    ,
    input  logic                  i_clearErrors,
    output logic                  o_overflow,
    output logic                  o_underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0] AF_LVL = CW'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL = CW'(ALMOST_EMPTY_LEVEL);

    // Parameter sanity checks, evaluated at elaboration time.
    if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
        $error("fifo_sync_param: DATA_WIDTH must be in 1..64");
    end
    if (ADDR_WIDTH < 1 || DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be at least 2");
    end
    if (ALMOST_EMPTY_LEVEL >= ALMOST_FULL_LEVEL) begin : g_bad_ae
        $error("fifo_sync_param: ALMOST_EMPTY_LEVEL must be below ALMOST_FULL_LEVEL");
    end
    if (ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_sync_param: ALMOST_FULL_LEVEL must not exceed DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   fill_count;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // Status decode from the registered pointers, so flags track the last edge with no extra delay.
    always_comb begin
        fill_count = wr_ptr_q - rd_ptr_q;
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    end

    // Accept decisions. Full or empty gating ensures that a read and a write never hit the same address.
    always_comb begin
        wr_acc = i_writeEnable && !full;
        rd_acc = i_readEnable && !empty;
    end

    // Next-state logic for the pointers and the read strobe.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_acc;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and strobe registers. A synchronous reset discards all stored words.
    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // RAM write port. Contents are not reset, and writes are suppressed while in reset.
    always_ff @(posedge i_clock) begin
        if (i_nReset && wr_acc) begin
            mem[wr_addr] <= i_writeData;
        end
    end

    // RAM read port. It stays in a clocked block so the read maps onto the block RAM output register.
    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            rd_data_q <= '0;
        end else if (rd_acc) begin
            rd_data_q <= mem[rd_addr];
        end
    end

`ifdef LCD_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky error flags. A new error in the same cycle as a clear wins.
    always_comb begin
        ovf_d = (ovf_q && !i_clearErrors) || (i_writeEnable && full);
        udf_d = (udf_q && !i_clearErrors) || (i_readEnable && empty);
    end

    // Error flag registers.
    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;
`endif

    assign o_full        = full;
    assign o_empty       = empty;
    assign o_fillCount   = fill_count;
    assign o_almostFull  = (fill_count >= AF_LVL);
    assign o_almostEmpty = (fill_count <= AE_LVL);
    assign o_readData    = rd_data_q;
    assign o_readValid   = rd_valid_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Testbench for fifo_sync_param (DATA_WIDTH=32, ADDR_WIDTH=4).
// A queue-based reference model is checked against the DUT on every falling
// edge. Directed steps also pin selected outputs to hand-computed literals.
module tb_fifo_sync_param;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int AEL   = 4;

    logic          clk = 1'b0;
    logic          i_nReset;
    logic [DW-1:0] i_writeData;
    logic          i_writeEnable;
    logic          i_readEnable;
    logic          i_clearErrors;
    logic          o_full, o_almostFull, o_empty, o_almostEmpty, o_readValid;
    logic [DW-1:0] o_readData;
    logic [AW:0]   o_fillCount;
    logic          o_overflow, o_underflow;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rdata;
    bit            m_rvalid;
    bit            m_ovf;
    bit            m_udf;
    bit            model_on = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_param #(
        .DATA_WIDTH        (DW),
        .ADDR_WIDTH        (AW),
        .ALMOST_FULL_LEVEL (AFL),
        .ALMOST_EMPTY_LEVEL(AEL)
    ) dut (
        .i_clock      (clk),
        .i_nReset     (i_nReset),
        .i_writeData  (i_writeData),
        .i_writeEnable(i_writeEnable),
        .o_full       (o_full),
        .o_almostFull (o_almostFull),
        .i_readEnable (i_readEnable),
        .o_readData   (o_readData),
        .o_readValid  (o_readValid),
        .o_empty      (o_empty),
        .o_almostEmpty(o_almostEmpty),
        .o_fillCount  (o_fillCount)
`ifdef LCD_FIFO_ERR_EN
        ,
        .i_clearErrors(i_clearErrors),
        .o_overflow   (o_overflow),
        .o_underflow  (o_underflow)
`endif
    );

`ifndef LCD_FIFO_ERR_EN
    assign o_overflow  = 1'b0;
    assign o_underflow = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The reference model applies the FIFO rules to a queue, using the state from before the edge.
    task automatic model_step(input bit nrst, input bit we, input logic [DW-1:0] wd,
                              input bit re, input bit clr);
        bit m_full, m_empty, wa, ra;
        if (!nrst) begin
            m_q.delete();
            m_rdata  = '0;
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
        end else begin
            m_full   = (m_q.size() == DEPTH);
            m_empty  = (m_q.size() == 0);
            wa       = we && !m_full;
            ra       = re && !m_empty;
            m_ovf    = (m_ovf && !clr) || (we && m_full);
            m_udf    = (m_udf && !clr) || (re && m_empty);
            m_rvalid = ra;
            if (ra) m_rdata = m_q.pop_front();
            if (wa) m_q.push_back(wd);
        end
    endtask

    // Drive one clock cycle, update the model at the edge, then let the outputs settle.
    task automatic cyc(input bit nrst, input bit we, input logic [DW-1:0] wd,
                       input bit re, input bit clr);
        i_nReset      = nrst;
        i_writeEnable = we;
        i_writeData   = wd;
        i_readEnable  = re;
        i_clearErrors = clr;
        @(posedge clk);
        model_step(nrst, we, wd, re, clr);
        model_on = 1'b1;
        #2;
    endtask

    // Compare all DUT outputs against the model on every falling edge once the model is live.
    always @(negedge clk) begin
        if (model_on) begin
            chk("cmp_count",    64'(o_fillCount),   64'(m_q.size()));
            chk("cmp_empty",    64'(o_empty),       64'(m_q.size() == 0));
            chk("cmp_full",     64'(o_full),        64'(m_q.size() == DEPTH));
            chk("cmp_afull",    64'(o_almostFull),  64'(m_q.size() >= AFL));
            chk("cmp_aempty",   64'(o_almostEmpty), 64'(m_q.size() <= AEL));
            chk("cmp_rvalid",   64'(o_readValid),   64'(m_rvalid));
            chk("cmp_rdata",    64'(o_readData),    64'(m_rdata));
`ifdef LCD_FIFO_ERR_EN
            chk("cmp_overflow",  64'(o_overflow),  64'(m_ovf));
            chk("cmp_underflow", 64'(o_underflow), 64'(m_udf));
`endif
        end
    end

    initial begin
        i_nReset      = 1'b0;
        i_writeEnable = 1'b0;
        i_readEnable  = 1'b0;
        i_writeData   = '0;
        i_clearErrors = 1'b0;

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_count", 64'(o_fillCount), 64'd0);
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_aempty", 64'(o_almostEmpty), 64'd1);
        chk("rst_full", 64'(o_full), 64'd0);
        chk("rst_rdata", 64'(o_readData), 64'd0);
        chk("rst_rvalid", 64'(o_readValid), 64'd0);

        // Fill with 16 words, no reads.
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 32'h1000 + i, 0, 0);
            chk("fill_count", 64'(o_fillCount), 64'(i + 1));
            chk("fill_afull", 64'(o_almostFull), 64'(i + 1 >= 12));
        end
        chk("fill_full", 64'(o_full), 64'd1);
        cyc(1, 1, 32'hDEAD_BEEF, 0, 0);
        chk("fill_17th_count", 64'(o_fillCount), 64'd16);

        // Drain in order.
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 1, 0);
            chk("drain_valid", 64'(o_readValid), 64'd1);
            chk("drain_data", 64'(o_readData), 64'(32'h1000 + i));
            chk("drain_aempty", 64'(o_almostEmpty), 64'(15 - i <= 4));
        end
        chk("drain_empty", 64'(o_empty), 64'd1);
        cyc(1, 0, 0, 1, 0);
        chk("drain_17th_valid", 64'(o_readValid), 64'd0);
        chk("drain_17th_hold", 64'(o_readData), 64'h100F);

        // Stream 40 words with simultaneous read and write across pointer wraps.
        cyc(1, 1, 32'h3000, 0, 0);
        for (int i = 1; i < 40; i++) begin
            cyc(1, 1, 32'h3000 + i, 1, 0);
            chk("wrap_data", 64'(o_readData), 64'(32'h3000 + i - 1));
            chk("wrap_count", 64'(o_fillCount), 64'd1);
        end
        cyc(1, 0, 0, 1, 0);
        chk("wrap_last", 64'(o_readData), 64'h3027);

        // Full plus simultaneous read and write: the read wins and the new word is dropped.
        for (int i = 0; i < 16; i++) cyc(1, 1, 32'h2000 + i, 0, 0);
        cyc(1, 1, 32'h0000_BEEF, 1, 0);
        chk("fullrw_count", 64'(o_fillCount), 64'd15);
        chk("fullrw_data", 64'(o_readData), 64'h2000);
        for (int i = 0; i < 15; i++) cyc(1, 0, 0, 1, 0);
        chk("fullrw_last", 64'(o_readData), 64'h200F);
        chk("fullrw_empty", 64'(o_empty), 64'd1);

        // Empty plus simultaneous read and write: the write wins.
        cyc(1, 1, 32'h55, 1, 0);
        chk("emptyrw_count", 64'(o_fillCount), 64'd1);
        chk("emptyrw_valid", 64'(o_readValid), 64'd0);
        cyc(1, 0, 0, 1, 0);
        chk("emptyrw_valid2", 64'(o_readValid), 64'd1);
        chk("emptyrw_data", 64'(o_readData), 64'h55);

        // Reset in the middle of operation, with both enables high.
        for (int i = 0; i < 7; i++) cyc(1, 1, 32'h5000 + i, 0, 0);
        chk("mid_count", 64'(o_fillCount), 64'd7);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 1, 32'h5555, 1, 0);
        chk("midrst_count", 64'(o_fillCount), 64'd0);
        chk("midrst_empty", 64'(o_empty), 64'd1);
        chk("midrst_valid", 64'(o_readValid), 64'd0);
        chk("midrst_data", 64'(o_readData), 64'd0);
        cyc(1, 0, 0, 0, 0);

        // Error flags: overflow, underflow, hold, then clear.
        for (int i = 0; i < 16; i++) cyc(1, 1, 32'h4000 + i, 0, 0);
        cyc(1, 1, 32'h4444, 0, 0);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 1, 0);
        chk("err_drained", 64'(o_empty), 64'd1);
        cyc(1, 0, 0, 1, 0);
`ifdef LCD_FIFO_ERR_EN
        chk("err_overflow", 64'(o_overflow), 64'd1);
        chk("err_underflow", 64'(o_underflow), 64'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk("err_hold_ovf", 64'(o_overflow), 64'd1);
            chk("err_hold_udf", 64'(o_underflow), 64'd1);
        end
        cyc(1, 0, 0, 0, 1);
        chk("err_clr_ovf", 64'(o_overflow), 64'd0);
        chk("err_clr_udf", 64'(o_underflow), 64'd0);
`else
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
`endif
        cyc(1, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
